normalizer_to28: RTL and testbench
==================================

NORMALIZER_TO28 -- requirements
Module: normalizer_to28

Interface
REQ-001 The block SHALL have a single clock `clk`; reset `reset` SHALL be synchronous and active-low.
REQ-002 `clk`  input  1  rising-edge clock for all state.
REQ-003 `reset`  input  1  synchronous active-low reset, sampled on the rising `clk` edge.
REQ-004 `start`  input  1  request to normalize; accepted only in IDLE.
REQ-005 `mantissa_in`  input  64  unsigned significand to normalize.
REQ-006 `exponent_in`  input  12  signed exponent paired with `mantissa_in`.
REQ-007 `busy`  output  1  high in SHIFT and DONE states.
REQ-008 `done`  output  1  one-cycle pulse; results are valid while `done` is high.
REQ-009 `mantissa_out`  output  64  normalized significand, with its leading one at bit 28.
REQ-010 `exponent_out`  output  12  signed adjusted exponent.
REQ-011 `shift_count`  output  7  signed net shift applied (+ = right, - = left); range -28..+35.
REQ-012 `zero`  output  1  set when `mantissa_in` was zero.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE, `start`=1: on the edge, load `mantissa_in` and `exponent_in` into working registers, clear `shift_count`, and go to SHIFT.
REQ-015 IDLE, `start`=0: remain in IDLE; all outputs hold their last values.
REQ-016 SHIFT, per edge, when the leading one is above bit 28: shift right by 1, add 1 to the exponent, add 1 to `shift_count`.
REQ-017 SHIFT, per edge, when the leading one is below bit 28: shift left by 1, subtract 1 from the exponent, subtract 1 from `shift_count`.
REQ-018 SHIFT, when the leading one is at bit 28 or the mantissa is zero: no shift occurs; go to DONE and set `zero` iff the mantissa is zero.
REQ-019 DONE: assert `done` for exactly one cycle, then go to IDLE.
REQ-020 Exactly one shift SHALL occur per cycle.
REQ-021 Latency: `done` SHALL be high in the cycle following edge k+|d|+1, where k is the accepting edge and d is the net shift.
REQ-022 Worst-case latency SHALL be 37 cycles (leading one at bit 63, d=+35).
REQ-023 Exponent arithmetic SHALL be 12-bit two's complement and wrap on overflow, with no saturation and no flag.
REQ-024 Left shifts SHALL fill bit 0 with 0; right shifts SHALL fill bit 63 with 0.
REQ-025 `start` while `busy`=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-026 `start` in the same cycle `done`=1 SHALL be ignored; a new request is accepted only once the FSM is back in IDLE.
REQ-027 `mantissa_out`, `exponent_out`, `shift_count` and `zero` SHALL update only on shift/DONE transitions; they are stable while `done`=1.

Reset
REQ-028 When `reset`=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-029 When `reset`=0 at a rising edge, `busy`, `done`, `zero`, `mantissa_out`, `exponent_out` and `shift_count` SHALL all be 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no `done` pulse is produced for the aborted request.
REQ-031 Reset SHALL take priority over `start` in the same cycle.

Configuration
REQ-032 Macro `NORMALIZER_STICKY_EN`, when defined, SHALL make each right shift OR the bit shifted out of bit 0 into the new bit 0 (sticky retention for rounding).
REQ-033 Without `NORMALIZER_STICKY_EN`, shifted-out bits SHALL be discarded; behaviour is otherwise identical, including latency.

Verification
REQ-034 Positive distance: `mantissa_in`=1<<35, `exponent_in`=100 -> `done` after 9 edges; `mantissa_out`=1<<28, `exponent_out`=107, `shift_count`=+7, `zero`=0.
REQ-035 Negative distance: `mantissa_in`=1<<23, `exponent_in`=100 -> `mantissa_out`=1<<28, `exponent_out`=95, `shift_count`=-5, `done` after 7 edges.
REQ-036 Zero input: `mantissa_in`=0, `exponent_in`=-3 -> `done` after 2 edges; `zero`=1, `mantissa_out`=0, `exponent_out`=-3, `shift_count`=0.
REQ-037 Sticky: `mantissa_in`=(1<<35)|1 -> `mantissa_out`=(1<<28)|1 with `NORMALIZER_STICKY_EN`; `mantissa_out`=1<<28 without it.
REQ-038 Reset mid-op: `mantissa_in`=1<<63 started, `reset`=0 at edge 10 -> no `done`; all outputs 0; a new `start` is accepted on the next edge with `reset`=1.
REQ-039 Start while busy: a second `start` with `mantissa_in`=1<<40 during a 1<<35 operation -> ignored; the result matches REQ-034.

Source files
------------

// File: rtl/normalizer_to28.sv
// normalizer_to28: shifts a 64-bit significand one bit per cycle until its
//   leading one sits at bit 28, adjusting a 12-bit signed exponent to match.
// Latency: done is high in the cycle after edge k+|d|+1 (k = accept edge,
//   d = net shift); the worst case is 37 cycles. No backpressure: start is
//   accepted only in IDLE and ignored while busy or while done is high.
// Ports: clk, reset (sync, active-low), start, mantissa_in[63:0],
//   exponent_in[11:0] -> busy, done, mantissa_out[63:0], exponent_out[11:0],
//   shift_count[6:0] (signed, + = right), zero.
// Build option: define NORMALIZER_STICKY_EN to OR each bit shifted out of
//   bit 0 back into the new bit 0 on right shifts (sticky for rounding).
module normalizer_to28 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] mantissa_in,
  input  logic [11:0] exponent_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] mantissa_out,
  output logic [11:0] exponent_out,
  output logic [6:0]  shift_count,
  output logic        zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;

  // Working registers; the visible outputs are only copied from these when
  // the result is final, so outputs never move during a shift sequence.
  logic [63:0] r_mant;
  logic [11:0] r_exp;
  logic [6:0]  r_cnt;

  logic        r_busy;
  logic        r_done;
  logic        r_zero;
  logic [63:0] r_mant_out;
  logic [11:0] r_exp_out;
  logic [6:0]  r_cnt_out;

  logic        w_above;
  logic        w_at;
  logic        w_is_zero;
  logic [63:0] w_mant_rsh;
  logic [63:0] w_mant_lsh;

  // Leading one above bit 28 iff any bit in [63:29] is set; exactly at 28
  // iff bit 28 is set and nothing above it. Otherwise it is below (or zero).
  assign w_above   = |r_mant[63:29];
  assign w_at      = r_mant[28] & ~w_above;
  assign w_is_zero = ~|r_mant;

  assign w_mant_lsh = {r_mant[62:0], 1'b0};

  always_comb begin
    w_mant_rsh = {1'b0, r_mant[63:1]};
`ifdef NORMALIZER_STICKY_EN
    // Keep evidence of any discarded one in bit 0 for later rounding.
    w_mant_rsh[0] = r_mant[1] | r_mant[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mant     <= 64'd0;
      r_exp      <= 12'd0;
      r_cnt      <= 7'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_zero     <= 1'b0;
      r_mant_out <= 64'd0;
      r_exp_out  <= 12'd0;
      r_cnt_out  <= 7'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mant  <= mantissa_in;
            r_exp   <= exponent_in;
            r_cnt   <= 7'd0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_is_zero || w_at) begin
            r_mant_out <= r_mant;
            r_exp_out  <= r_exp;
            r_cnt_out  <= r_cnt;
            r_zero     <= w_is_zero;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_above) begin
            r_mant <= w_mant_rsh;
            r_exp  <= r_exp + 12'd1;
            r_cnt  <= r_cnt + 7'd1;
          end else begin
            r_mant <= w_mant_lsh;
            r_exp  <= r_exp - 12'd1;
            r_cnt  <= r_cnt - 7'd1;
          end
        end

        S_DONE: begin
          // start seen here is dropped: only IDLE accepts requests.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign zero         = r_zero;
  assign mantissa_out = r_mant_out;
  assign exponent_out = r_exp_out;
  assign shift_count  = r_cnt_out;

endmodule

// File: tb/tb_normalizer_to28.sv
// Self-checking bench for normalizer_to28: directed vector table, hand-built
// reset/start-while-busy sequences, and random operands checked against a
// leading-one-position reference model.
module tb_normalizer_to28;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] mantissa_in;
  logic [11:0] exponent_in;
  logic        busy;
  logic        done;
  logic [63:0] mantissa_out;
  logic [11:0] exponent_out;
  logic [6:0]  shift_count;
  logic        zero;

  int checks = 0;
  int errors = 0;

  normalizer_to28 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mantissa_in  (mantissa_in),
    .exponent_in  (exponent_in),
    .busy         (busy),
    .done         (done),
    .mantissa_out (mantissa_out),
    .exponent_out (exponent_out),
    .shift_count  (shift_count),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] m;
    logic [11:0] e;
    logic [63:0] xm;
    logic [11:0] xe;
    logic [6:0]  xc;
    logic        xz;
    int          xedges;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: locate the leading one, the net shift is its distance from
  // bit 28; shift the whole value in one go.
  task automatic model(input logic [63:0] m, input logic [11:0] e,
                       output logic [63:0] mo, output logic [11:0] eo,
                       output logic [6:0] co, output logic z, output int edges);
    int p;
    int d;
    logic [63:0] mask;
    p = -1;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    if (p < 0) begin
      mo = 64'd0; eo = e; co = 7'd0; z = 1'b1; edges = 2;
    end else begin
      d = p - 28;
      z = 1'b0;
      if (d >= 0) begin
        mo = m >> d;
`ifdef NORMALIZER_STICKY_EN
        mask = (64'd1 << d) - 64'd1;
        if ((m & mask) != 64'd0) mo[0] = 1'b1;
`else
        mask = 64'd0;
`endif
      end else begin
        mo = m << (-d);
        mask = 64'd0;
      end
      eo = e + 12'(d);
      co = 7'(d);
      edges = (d < 0 ? -d : d) + 2;
    end
  endtask

  // Call just after a negedge. Applies one request and checks the result,
  // its latency, the one-cycle done pulse, and output stability afterwards.
  // With poke set, start stays high with a different operand for the whole
  // operation including the done cycle; none of it may be accepted.
  task automatic do_op(input logic [63:0] m, input logic [11:0] e,
                       input logic [63:0] xm, input logic [11:0] xe,
                       input logic [6:0] xc, input logic xz, input int xedges,
                       input bit poke, input string tag);
    int n;
    mantissa_in = m;
    exponent_in = e;
    start = 1'b1;
    @(negedge clk);
    n = 1;
    chk({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    if (poke) begin
      mantissa_in = 64'd1 << 40;
      exponent_in = 12'd7;
    end else begin
      start = 1'b0;
    end
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done after %0d edges, want %0d", tag, n, xedges);
      start = 1'b0;
      @(negedge clk);
    end else begin
      chk({tag, "_latency"}, 64'(n), 64'(xedges));
      chk({tag, "_mantissa"}, mantissa_out, xm);
      chk({tag, "_exponent"}, 64'(exponent_out), 64'(xe));
      chk({tag, "_shift_count"}, 64'(shift_count), 64'(xc));
      chk({tag, "_zero"}, 64'(zero), 64'(xz));
      chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      chk({tag, "_idle_after_done"}, 64'(busy), 64'd0);
      chk({tag, "_mantissa_hold"}, mantissa_out, xm);
      start = 1'b0;
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic [63:0] rm;
    logic [63:0] mo;
    logic [11:0] re;
    logic [11:0] eo;
    logic [6:0]  co;
    logic        zo;
    int          ed;
    int          p;
    int          seen;

    vecs[0] = '{64'd1 << 35, 12'd100, 64'd1 << 28, 12'd107, 7'd7, 1'b0, 9};
    vecs[1] = '{64'd1 << 23, 12'd100, 64'd1 << 28, 12'd95, 7'h7B, 1'b0, 7};
    vecs[2] = '{64'd0, 12'hFFD, 64'd0, 12'hFFD, 7'd0, 1'b1, 2};
`ifdef NORMALIZER_STICKY_EN
    vecs[3] = '{(64'd1 << 35) | 64'd1, 12'd0, (64'd1 << 28) | 64'd1, 12'd7, 7'd7, 1'b0, 9};
    vecs[8] = '{(64'd1 << 29) | 64'd1, 12'h800, (64'd1 << 28) | 64'd1, 12'h801, 7'd1, 1'b0, 3};
`else
    vecs[3] = '{(64'd1 << 35) | 64'd1, 12'd0, 64'd1 << 28, 12'd7, 7'd7, 1'b0, 9};
    vecs[8] = '{(64'd1 << 29) | 64'd1, 12'h800, 64'd1 << 28, 12'h801, 7'd1, 1'b0, 3};
`endif
    vecs[4] = '{64'd1 << 63, 12'd0, 64'd1 << 28, 12'd35, 7'd35, 1'b0, 37};
    vecs[5] = '{64'd1, 12'd0, 64'd1 << 28, 12'hFE4, 7'h64, 1'b0, 30};
    vecs[6] = '{(64'd1 << 28) | 64'd5, 12'd5, (64'd1 << 28) | 64'd5, 12'd5, 7'd0, 1'b0, 2};
    vecs[7] = '{64'd1 << 63, 12'h7FF, 64'd1 << 28, 12'h822, 7'd35, 1'b0, 37};
    vecs[9] = '{64'd3, 12'h805, 64'h18000000, 12'h7EA, 7'h65, 1'b0, 29};

    reset = 1'b0;
    start = 1'b0;
    mantissa_in = 64'd0;
    exponent_in = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_mantissa", mantissa_out, 64'd0);
    chk("reset_exponent", 64'(exponent_out), 64'd0);
    chk("reset_shift_count", 64'(shift_count), 64'd0);
    chk("reset_zero", 64'(zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].m, vecs[i].e, vecs[i].xm, vecs[i].xe, vecs[i].xc,
            vecs[i].xz, vecs[i].xedges, 1'b0, $sformatf("vec%0d", i));
    end

    // Start while busy and during done: second operand must be ignored.
    do_op(64'd1 << 35, 12'd100, 64'd1 << 28, 12'd107, 7'd7, 1'b0, 9, 1'b1, "busy_poke");

    // Reset mid-operation, with start also high at the reset edge.
    mantissa_in = 64'd1 << 63;
    exponent_in = 12'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    reset = 1'b0;
    start = 1'b1;
    mantissa_in = 64'd1 << 40;
    @(negedge clk);
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_mantissa", mantissa_out, 64'd0);
    chk("abort_exponent", 64'(exponent_out), 64'd0);
    chk("abort_shift_count", 64'(shift_count), 64'd0);
    chk("abort_zero", 64'(zero), 64'd0);
    reset = 1'b1;
    do_op(64'd1 << 35, 12'd100, 64'd1 << 28, 12'd107, 7'd7, 1'b0, 9, 1'b0, "after_abort");

    // Random operands with a random leading-one position (or zero).
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 64);
      rm = {$urandom, $urandom};
      if (p == 64) rm = 64'd0;
      else rm = (64'd1 << p) | (rm & ((64'd1 << p) - 64'd1));
      re = 12'($urandom);
      model(rm, re, mo, eo, co, zo, ed);
      do_op(rm, re, mo, eo, co, zo, ed, (i % 5) == 0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
